// File: rtl/ram_arbiter.sv
// ram_arbiter: two-way round-robin arbiter and command sequencer for the
// single-port SPI RAM. Each accepted read/write becomes an address word and
// a data word on ram_din. Reads then wait for ram_tx_valid, or time out.
//
// Ports:
//   clk, rst                     rising-edge clock, synchronous active-high reset
//   req_valid/write/addr/wdata*  transaction request from requester 0 / 1
//   req_ready*                   acceptance (combinational, IDLE only)
//   rsp_valid/data/err*          one-cycle completion pulse with read data / timeout flag
//   ram_din, ram_rx_valid        command word to the RAM ({opcode[1:0], payload})
//   ram_dout, ram_tx_valid       read data returned by the RAM
module ram_arbiter #(
   parameter int ADDR_SIZE = 8,
   parameter int TIMEOUT   = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid0,
   input  logic                 req_valid1,
   input  logic                 req_write0,
   input  logic                 req_write1,
   input  logic [ADDR_SIZE-1:0] req_addr0,
   input  logic [ADDR_SIZE-1:0] req_addr1,
   input  logic [ADDR_SIZE-1:0] req_wdata0,
   input  logic [ADDR_SIZE-1:0] req_wdata1,
   output logic                 req_ready0,
   output logic                 req_ready1,
   output logic                 rsp_valid0,
   output logic                 rsp_valid1,
   output logic [ADDR_SIZE-1:0] rsp_data0,
   output logic [ADDR_SIZE-1:0] rsp_data1,
   output logic                 rsp_err0,
   output logic                 rsp_err1,
   output logic [ADDR_SIZE+1:0] ram_din,
   output logic                 ram_rx_valid,
   input  logic [ADDR_SIZE-1:0] ram_dout,
   input  logic                 ram_tx_valid
);

   localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      DATA,
      WAIT_RD,
      RESP
   } state_t;

   state_t               state;
   logic                 g;
   logic                 g_q;
   logic                 last_grant;
   logic                 wr_q;
   logic [ADDR_SIZE-1:0] wdata_q;
   logic [7:0]           cnt;
   logic [7:0]           cnt_inc;
   logic                 idle_ok;
   logic                 accept;
   logic                 sel_write;
   logic [ADDR_SIZE-1:0] sel_addr;
   logic [ADDR_SIZE-1:0] sel_wdata;

   // Single requester wins outright; on a tie the one not served last wins.
   assign g = req_valid1 & (~req_valid0 | ~last_grant);

   // Ready is held low while rst is asserted so every output reads 0 then.
   assign idle_ok    = (state == IDLE) & ~rst;
   assign req_ready0 = idle_ok & req_valid0 & ~g;
   assign req_ready1 = idle_ok & req_valid1 & g;
   assign accept     = req_ready0 | req_ready1;

   assign sel_write = g ? req_write1 : req_write0;
   assign sel_addr  = g ? req_addr1  : req_addr0;
   assign sel_wdata = g ? req_wdata1 : req_wdata0;

   assign cnt_inc = cnt + 8'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         last_grant   <= 1'b1;
         g_q          <= 1'b0;
         wr_q         <= 1'b0;
         wdata_q      <= '0;
         cnt          <= '0;
         ram_din      <= '0;
         ram_rx_valid <= 1'b0;
         rsp_valid0   <= 1'b0;
         rsp_valid1   <= 1'b0;
         rsp_data0    <= '0;
         rsp_data1    <= '0;
         rsp_err0     <= 1'b0;
         rsp_err1     <= 1'b0;
      end else begin
         rsp_valid0 <= 1'b0;
         rsp_valid1 <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  g_q          <= g;
                  wr_q         <= sel_write;
                  wdata_q      <= sel_wdata;
                  ram_rx_valid <= 1'b1;
                  ram_din      <= {sel_write ? OP_WR_ADDR : OP_RD_ADDR,
                                   sel_addr};
                  state        <= ADDR;
               end
            end
            ADDR: begin
               ram_din <= wr_q ? {OP_WR_DATA, wdata_q}
                               : {OP_RD_DATA, {ADDR_SIZE{1'b0}}};
               state   <= DATA;
            end
            DATA: begin
               ram_rx_valid <= 1'b0;
               if (wr_q) begin
                  if (g_q) begin
                     rsp_valid1 <= 1'b1;
                     rsp_data1  <= '0;
                     rsp_err1   <= 1'b0;
                  end else begin
                     rsp_valid0 <= 1'b1;
                     rsp_data0  <= '0;
                     rsp_err0   <= 1'b0;
                  end
                  state <= RESP;
               end else begin
                  cnt   <= '0;
                  state <= WAIT_RD;
               end
            end
            WAIT_RD: begin
               // Returned data beats a coincident timeout.
               if (ram_tx_valid) begin
                  if (g_q) begin
                     rsp_valid1 <= 1'b1;
                     rsp_data1  <= ram_dout;
                     rsp_err1   <= 1'b0;
                  end else begin
                     rsp_valid0 <= 1'b1;
                     rsp_data0  <= ram_dout;
                     rsp_err0   <= 1'b0;
                  end
                  state <= RESP;
               end else if (cnt_inc == TO_LIMIT) begin
                  if (g_q) begin
                     rsp_valid1 <= 1'b1;
                     rsp_data1  <= '0;
                     rsp_err1   <= 1'b1;
                  end else begin
                     rsp_valid0 <= 1'b1;
                     rsp_data0  <= '0;
                     rsp_err0   <= 1'b1;
                  end
                  state <= RESP;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            RESP: begin
               last_grant <= g_q;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed, table-driven bench for ram_arbiter.
// Drives and samples on the falling edge; DUT state changes on the rising edge.
module tb_ram_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid0, req_valid1;
   logic       req_write0, req_write1;
   logic [7:0] req_addr0, req_addr1;
   logic [7:0] req_wdata0, req_wdata1;
   logic       req_ready0, req_ready1;
   logic       rsp_valid0, rsp_valid1;
   logic [7:0] rsp_data0, rsp_data1;
   logic       rsp_err0, rsp_err1;
   logic [9:0] ram_din;
   logic       ram_rx_valid;
   logic [7:0] ram_dout;
   logic       ram_tx_valid;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ram_arbiter #(.ADDR_SIZE(8), .TIMEOUT(15)) dut (
      .clk(clk), .rst(rst),
      .req_valid0(req_valid0), .req_valid1(req_valid1),
      .req_write0(req_write0), .req_write1(req_write1),
      .req_addr0(req_addr0), .req_addr1(req_addr1),
      .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
      .req_ready0(req_ready0), .req_ready1(req_ready1),
      .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
      .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
      .rsp_err0(rsp_err0), .rsp_err1(rsp_err1),
      .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
      .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
   );

   typedef struct {
      logic       r;
      logic       wr;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic       stray;
      int         delay;
      logic [7:0] ram_data;
      logic [9:0] din0;
      logic [9:0] din1;
      int         lat;
      logic [7:0] data;
      logic       err;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   task automatic set_req(input logic r, input logic v, input logic wr,
                          input logic [7:0] a, input logic [7:0] d);
      if (r) begin
         req_valid1 = v; req_write1 = wr;
         req_addr1 = a;  req_wdata1 = d;
      end else begin
         req_valid0 = v; req_write0 = wr;
         req_addr0 = a;  req_wdata0 = d;
      end
   endtask

   task automatic run_vec(input int i);
      vec_t v;
      logic got;
      int   lat;
      logic [1:0] rv;
      v = tbl[i];
      @(negedge clk);
      set_req(v.r, 1'b1, v.wr, v.addr, v.wdata);
      #1;
      chk($sformatf("v%0d ready_g", i), v.r ? req_ready1 : req_ready0, 1);
      chk($sformatf("v%0d ready_o", i), v.r ? req_ready0 : req_ready1, 0);
      @(negedge clk);
      set_req(v.r, 1'b0, 1'b0, 8'h00, 8'h00);
      chk($sformatf("v%0d din_a", i), {ram_rx_valid, ram_din},
          {1'b1, v.din0});
      if (v.stray) begin
         ram_tx_valid = 1'b1;
         ram_dout     = 8'hFF;
      end
      @(negedge clk);
      ram_tx_valid = 1'b0;
      ram_dout     = 8'hEE;
      chk($sformatf("v%0d din_d", i), {ram_rx_valid, ram_din},
          {1'b1, v.din1});
      got = 1'b0;
      lat = 0;
      for (int k = 3; k < 40 && !got; k++) begin
         @(negedge clk);
         rv = {rsp_valid1, rsp_valid0};
         if (k == 3)
            chk($sformatf("v%0d din_hold", i), {ram_rx_valid, ram_din},
                {1'b0, v.din1});
         if (rv[~v.r])
            chk($sformatf("v%0d rsp_other", i), rv[~v.r], 0);
         if (rv[v.r]) begin
            got = 1'b1;
            lat = k;
         end else begin
            ram_tx_valid = (v.delay >= 0) && (k == 3 + v.delay);
            ram_dout     = ram_tx_valid ? v.ram_data : 8'hEE;
         end
      end
      ram_tx_valid = 1'b0;
      chk($sformatf("v%0d rsp_seen", i), got, 1);
      chk($sformatf("v%0d latency", i), lat, v.lat);
      chk($sformatf("v%0d rsp_data", i), v.r ? rsp_data1 : rsp_data0,
          v.data);
      chk($sformatf("v%0d rsp_err", i), v.r ? rsp_err1 : rsp_err0, v.err);
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, " din"}, ram_din, 0);
      chk({nm, " rx_valid"}, ram_rx_valid, 0);
      chk({nm, " ready"}, {req_ready1, req_ready0}, 0);
      chk({nm, " rsp_valid"}, {rsp_valid1, rsp_valid0}, 0);
      chk({nm, " rsp_data"}, {rsp_data1, rsp_data0}, 0);
      chk({nm, " rsp_err"}, {rsp_err1, rsp_err0}, 0);
   endtask

   initial begin
      int  i0, i1, ngr, nrsp, pend;
      logic [7:0] expd;
      // r wr addr wdata stray delay ramdata din0 din1 lat data err
      tbl[0] = '{1'b0, 1'b1, 8'h3C, 8'hA5, 1'b0, -1, 8'h00,
                 10'h03C, 10'h1A5, 3, 8'h00, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 8'h3C, 8'h77, 1'b0, 0, 8'hA5,
                 10'h23C, 10'h300, 4, 8'hA5, 1'b0};
      tbl[2] = '{1'b0, 1'b0, 8'h55, 8'h00, 1'b0, -1, 8'h00,
                 10'h255, 10'h300, 18, 8'h00, 1'b1};
      tbl[3] = '{1'b1, 1'b0, 8'h80, 8'h00, 1'b1, 3, 8'h11,
                 10'h280, 10'h300, 7, 8'h11, 1'b0};
      tbl[4] = '{1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, -1, 8'h00,
                 10'h0FF, 10'h100, 3, 8'h00, 1'b0};
      tbl[5] = '{1'b0, 1'b0, 8'h01, 8'h00, 1'b0, 14, 8'h5A,
                 10'h201, 10'h300, 18, 8'h5A, 1'b0};
      tbl[6] = '{1'b0, 1'b0, 8'h02, 8'h00, 1'b0, 13, 8'hC3,
                 10'h202, 10'h300, 17, 8'hC3, 1'b0};

      rst = 1'b1;
      set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      ram_dout = 8'h00;
      ram_tx_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;

      for (int i = 0; i < 7; i++) run_vec(i);

      // Reset during the DATA word of a write: everything clears, no response.
      @(negedge clk);
      set_req(1'b0, 1'b1, 1'b1, 8'h10, 8'h20);
      @(negedge clk);
      set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clk);
      chk("mid din_d", ram_din, 10'h120);
      rst = 1'b1;
      @(negedge clk);
      chk_all_zero("mid_rst");
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("post_rst quiet",
             {ram_rx_valid, rsp_valid1, rsp_valid0}, 0);
      end

      // Both requesters saturated with writes: grants alternate from 0.
      i0 = 0; i1 = 0; ngr = 0; nrsp = 0; pend = -1;
      for (int c = 0; c < 80 && nrsp < 8; c++) begin
         @(negedge clk);
         if (rsp_valid0 | rsp_valid1) begin
            chk("arb rsp_route", {rsp_valid1, rsp_valid0},
                pend == 1 ? 2 : 1);
            chk("arb rsp_data", pend == 1 ? rsp_data1 : rsp_data0, 0);
            nrsp++;
         end
         set_req(1'b0, i0 < 4, 1'b1, 8'h40 + 8'(i0), 8'(i0));
         set_req(1'b1, i1 < 4, 1'b1, 8'h80 + 8'(i1), 8'(i1));
         #1;
         if (req_ready0 | req_ready1) begin
            chk("arb one_ready", req_ready0 & req_ready1, 0);
            chk("arb grant", req_ready1, ngr % 2);
            pend = req_ready1 ? 1 : 0;
            expd = req_ready1 ? 8'h80 + 8'(i1) : 8'h40 + 8'(i0);
            if (req_ready1) i1++;
            else            i0++;
            ngr++;
            @(negedge clk);
            chk("arb din_a", ram_din, {2'b00, expd});
            nrsp = nrsp;
         end
      end
      chk("arb responses", nrsp, 8);
      chk("arb grants", ngr, 8);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
      $finish;
   end

endmodule
